// File: rtl/alu_pkg.sv
// Shared opcode encoding, FSM states and operation classes for the ALU
// execution sequencer.
package alu_pkg;

   localparam int unsigned OP_W   = 4;
   localparam int unsigned CTRL_W = 13;

   localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
   localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
   localparam logic [OP_W-1:0] OP_MUL  = 4'd2;
   localparam logic [OP_W-1:0] OP_DIV  = 4'd3;
   localparam logic [OP_W-1:0] OP_SHR  = 4'd4;
   localparam logic [OP_W-1:0] OP_SHRA = 4'd5;
   localparam logic [OP_W-1:0] OP_SHL  = 4'd6;
   localparam logic [OP_W-1:0] OP_ROR  = 4'd7;
   localparam logic [OP_W-1:0] OP_ROL  = 4'd8;
   localparam logic [OP_W-1:0] OP_AND  = 4'd9;
   localparam logic [OP_W-1:0] OP_OR   = 4'd10;
   localparam logic [OP_W-1:0] OP_NEG  = 4'd11;
   localparam logic [OP_W-1:0] OP_NOT  = 4'd12;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_EXEC,
      ST_WRITE,
      ST_DONE
   } state_t;

   typedef enum logic [1:0] {
      CLS_SIMPLE,
      CLS_MUL,
      CLS_DIV,
      CLS_ILLEGAL
   } op_class_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder: one-hot ALU control, legality flag and
// cycle class.
module alu_op_decode
   import alu_pkg::*;
(
   input  logic [OP_W-1:0]   opcode_i,
   output logic [CTRL_W-1:0] onehot_o,
   output logic              legal_o,
   output op_class_t         op_class_o
);

   always_comb begin
      onehot_o   = '0;
      legal_o    = 1'b0;
      op_class_o = CLS_ILLEGAL;
      if (opcode_i <= OP_NOT) begin
         onehot_o = CTRL_W'(1) << opcode_i;
         legal_o  = 1'b1;
         case (opcode_i)
            OP_MUL:  op_class_o = CLS_MUL;
            OP_DIV:  op_class_o = CLS_DIV;
            default: op_class_o = CLS_SIMPLE;
         endcase
      end
   end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Multi-cycle sequencer around the combinational ALU: latches operands, holds
// the one-hot control for a per-class number of cycles, then captures the result.
module alu_exec_ctrl
   import alu_pkg::*;
#(
   parameter int unsigned SIMPLE_CYCLES = 1,
   parameter int unsigned MUL_CYCLES    = 4,
   parameter int unsigned DIV_CYCLES    = 8
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        start,
   input  logic [3:0]  opcode,
   input  logic [31:0] rega,
   input  logic [31:0] regb,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [12:0] alu_ctrl,
   input  logic [63:0] alu_c,
   output logic [31:0] z_hi,
   output logic [31:0] z_lo,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam int unsigned MAX_A   = (SIMPLE_CYCLES > MUL_CYCLES) ? SIMPLE_CYCLES : MUL_CYCLES;
   localparam int unsigned MAX_CYC = (MAX_A > DIV_CYCLES) ? MAX_A : DIV_CYCLES;
   localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   state_t            state_q;
   logic [OP_W-1:0]   op_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_load_d;
   logic              err_pend_q;
   logic [31:0]       a_q, b_q, zhi_q, zlo_q, hi_q, lo_q;
   logic [CTRL_W-1:0] ctrl_q;
   logic              busy_q, done_q, err_q;

   logic [CTRL_W-1:0] dec_onehot;
   logic              dec_legal;
   op_class_t         dec_class;
   logic              reject;

   alu_op_decode u_dec (
      .opcode_i   (op_q),
      .onehot_o   (dec_onehot),
      .legal_o    (dec_legal),
      .op_class_o (dec_class)
   );

   always_comb begin
      cnt_load_d = CNT_W'(SIMPLE_CYCLES - 1);
      case (dec_class)
         CLS_MUL: cnt_load_d = CNT_W'(MUL_CYCLES - 1);
         CLS_DIV: cnt_load_d = CNT_W'(DIV_CYCLES - 1);
         default: ;
      endcase
   end

   assign reject = !dec_legal || ((dec_class == CLS_DIV) && (b_q == '0));

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q    <= ST_IDLE;
         op_q       <= '0;
         cnt_q      <= '0;
         err_pend_q <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         zhi_q      <= '0;
         zlo_q      <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         ctrl_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  a_q     <= rega;
                  b_q     <= regb;
                  op_q    <= opcode;
                  busy_q  <= 1'b1;
                  err_q   <= 1'b0;
                  state_q <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               // Rejected ops linger one extra LOAD cycle so the error done
               // lands two edges after the start was sampled.
               if (reject) begin
                  if (err_pend_q) begin
                     err_pend_q <= 1'b0;
                     err_q      <= 1'b1;
                     done_q     <= 1'b1;
                     state_q    <= ST_DONE;
                  end else begin
                     err_pend_q <= 1'b1;
                  end
               end else begin
                  cnt_q   <= cnt_load_d;
                  ctrl_q  <= dec_onehot;
                  state_q <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (cnt_q == '0) begin
                  state_q <= ST_WRITE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            ST_WRITE: begin
               zhi_q <= alu_c[63:32];
               zlo_q <= alu_c[31:0];
               if ((dec_class == CLS_MUL) || (dec_class == CLS_DIV)) begin
                  hi_q <= alu_c[63:32];
                  lo_q <= alu_c[31:0];
               end
               ctrl_q  <= '0;
               done_q  <= 1'b1;
               state_q <= ST_DONE;
            end
            ST_DONE: begin
               busy_q  <= 1'b0;
               err_q   <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign alu_a    = a_q;
   assign alu_b    = b_q;
   assign alu_ctrl = ctrl_q;
   assign z_hi     = zhi_q;
   assign z_lo     = zlo_q;
   assign hi       = hi_q;
   assign lo       = lo_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Scoreboard bench for alu_exec_ctrl with a behavioural combinational ALU.
module tb_alu_exec_ctrl;

   logic        clk = 1'b0;
   logic        clr = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  opcode = '0;
   logic [31:0] rega = '0, regb = '0;
   logic [31:0] alu_a, alu_b, z_hi, z_lo, hi, lo;
   logic [12:0] alu_ctrl;
   logic [63:0] alu_c;
   logic        busy, done, err;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      logic [31:0] zh, zl, h, l;
      logic        e;
      int          at;
   } exp_t;
   exp_t sb[$];

   alu_exec_ctrl #(.SIMPLE_CYCLES(1), .MUL_CYCLES(4), .DIV_CYCLES(8)) dut (
      .clk(clk), .clr(clr), .start(start), .opcode(opcode),
      .rega(rega), .regb(regb), .alu_a(alu_a), .alu_b(alu_b),
      .alu_ctrl(alu_ctrl), .alu_c(alu_c), .z_hi(z_hi), .z_lo(z_lo),
      .hi(hi), .lo(lo), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural ALU driven by the one-hot control
   always_comb begin
      alu_c = '0;
      case (alu_ctrl)
         13'h0001: alu_c = {32'h0, alu_a + alu_b};
         13'h0002: alu_c = {32'h0, alu_a - alu_b};
         13'h0004: alu_c = 64'(alu_a) * 64'(alu_b);
         13'h0008: alu_c = (alu_b != 0) ? {alu_a % alu_b, alu_a / alu_b} : '0;
         13'h0010: alu_c = {32'h0, alu_a >> alu_b[4:0]};
         13'h0020: alu_c = {32'h0, $unsigned($signed(alu_a) >>> alu_b[4:0])};
         13'h0040: alu_c = {32'h0, alu_a << alu_b[4:0]};
         13'h0080: alu_c = {32'h0, (alu_a >> alu_b[4:0]) | (alu_a << (6'd32 - {1'b0, alu_b[4:0]}))};
         13'h0100: alu_c = {32'h0, (alu_a << alu_b[4:0]) | (alu_a >> (6'd32 - {1'b0, alu_b[4:0]}))};
         13'h0200: alu_c = {32'h0, alu_a & alu_b};
         13'h0400: alu_c = {32'h0, alu_a | alu_b};
         13'h0800: alu_c = {32'h0, -alu_a};
         13'h1000: alu_c = {32'h0, ~alu_a};
         default:  alu_c = '0;
      endcase
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse is matched against the next expectation
   always @(negedge clk) begin
      if (done) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 64'(cyc), 64'(0));
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("z_hi", 64'(z_hi), 64'(e.zh));
            chk("z_lo", 64'(z_lo), 64'(e.zl));
            chk("hi", 64'(hi), 64'(e.h));
            chk("lo", 64'(lo), 64'(e.l));
            chk("err", 64'(err), 64'(e.e));
            chk("latency_edge", 64'(cyc), 64'(e.at));
         end
      end
   end

   // Drive one start pulse; lat = edges from start sample to done
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic [31:0] zh, input logic [31:0] zl,
                        input logic [31:0] h, input logic [31:0] l, input logic e,
                        input logic push);
      exp_t x;
      @(negedge clk);
      opcode = op; rega = a; regb = b; start = 1'b1;
      if (push) begin
         x.zh = zh; x.zl = zl; x.h = h; x.l = l; x.e = e; x.at = cyc + 1 + lat;
         sb.push_back(x);
      end
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", 64'(busy), 64'(1));
   endtask

   task automatic wait_done(input logic [12:0] onehot, input int exp_hits);
      int hits = 0;
      int bad = 0;
      bit got = 0;
      for (int i = 0; i < 40; i++) begin
         if (onehot != 0 && alu_ctrl == onehot) hits++;
         else if (alu_ctrl != 0) bad++;
         if (done) begin
            got = 1;
            break;
         end
         @(negedge clk);
      end
      if (!got) begin
         chk("done_timeout", 64'(0), 64'(1));
         if (sb.size() != 0) void'(sb.pop_front());
      end
      chk("ctrl_cycles", 64'(hits), 64'(exp_hits));
      chk("ctrl_stray", 64'(bad), 64'(0));
   endtask

   task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input int n, input logic [31:0] zh, input logic [31:0] zl,
                      input logic [31:0] h, input logic [31:0] l, input logic e);
      logic [12:0] oh;
      oh = e ? 13'h0 : (13'h1 << op);
      issue(op, a, b, e ? 2 : n + 2, zh, zl, h, l, e, 1'b1);
      wait_done(oh, e ? 0 : n + 1);
   endtask

   initial begin
      #1;
      chk("reset_state", {alu_a, alu_b}, 64'h0);
      chk("reset_z", {z_hi, z_lo}, 64'h0);
      chk("reset_hilo", {hi, lo}, 64'h0);
      chk("reset_flags", 64'({alu_ctrl, busy, done, err}), 64'h0);
      @(negedge clk);
      clr = 1'b1;

      run(4'd0,  32'd5,        32'd7,        1, 32'h0, 32'h0000000C, 32'h0, 32'h0, 1'b0);
      run(4'd1,  32'd3,        32'd5,        1, 32'h0, 32'hFFFFFFFE, 32'h0, 32'h0, 1'b0);
      run(4'd2,  32'h00010000, 32'h00010000, 4, 32'h1, 32'h0,        32'h1, 32'h0, 1'b0);
      run(4'd3,  32'd17,       32'd5,        8, 32'h2, 32'h3,        32'h2, 32'h3, 1'b0);
      run(4'd3,  32'd9,        32'd0,        8, 32'h2, 32'h3,        32'h2, 32'h3, 1'b1);
      run(4'hF,  32'd1,        32'd2,        1, 32'h2, 32'h3,        32'h2, 32'h3, 1'b1);
      run(4'd9,  32'h0000F0F0, 32'h0000FF00, 1, 32'h0, 32'h0000F000, 32'h2, 32'h3, 1'b0);
      run(4'd5,  32'h80000000, 32'd4,        1, 32'h0, 32'hF8000000, 32'h2, 32'h3, 1'b0);
      run(4'd8,  32'h80000001, 32'd1,        1, 32'h0, 32'h00000003, 32'h2, 32'h3, 1'b0);
      run(4'd12, 32'h0,        32'h0,        1, 32'h0, 32'hFFFFFFFF, 32'h2, 32'h3, 1'b0);

      // Start pulse during EXEC of a MUL must be ignored
      issue(4'd2, 32'd3, 32'd7, 6, 32'h0, 32'd21, 32'h0, 32'd21, 1'b0, 1'b1);
      @(negedge clk);
      opcode = 4'd0; rega = 32'd1; regb = 32'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(13'h0004, 4);

      // Asynchronous clear during EXEC aborts without a done pulse
      issue(4'd2, 32'd6, 32'd6, 6, '0, '0, '0, '0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      clr = 1'b0;
      #1;
      chk("abort_operands", {alu_a, alu_b}, 64'h0);
      chk("abort_z", {z_hi, z_lo}, 64'h0);
      chk("abort_hilo", {hi, lo}, 64'h0);
      chk("abort_busy", 64'(busy), 64'(0));
      chk("abort_ctrl_flags", 64'({alu_ctrl, done, err}), 64'h0);
      repeat (3) @(negedge clk);
      clr = 1'b1;

      run(4'd0, 32'h10, 32'h20, 1, 32'h0, 32'h30, 32'h0, 32'h0, 1'b0);

      repeat (12) @(negedge clk);
      chk("scoreboard_drained", 64'(sb.size()), 64'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
